// File: rtl/sdam_pkg.sv
// Shared SDAM link definitions used by the transmitter and the receiver.
// Holds the frame field widths, the fixed line levels, the frame state
// encoding, the latched request payload and the frame parity helper.
package sdam_pkg;

  localparam int unsigned SDAM_ADDR_W    = 8;
  localparam int unsigned SDAM_DATA_W    = 16;
  localparam int unsigned SDAM_BIT_CNT_W = 4;

  localparam logic SDAM_START_BIT = 1'b0;
  localparam logic SDAM_MODE_WR   = 1'b1;
  localparam logic SDAM_IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_MODE,
    ST_ADDR,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } sdam_state_e;

  typedef struct packed {
    logic [SDAM_DATA_W-1:0] data;
    logic [SDAM_ADDR_W-1:0] addr;
  } sdam_req_t;

  // XOR of all address and data bits; sending it makes the frame even parity.
  function automatic logic sdam_parity(input sdam_req_t req);
    return ^req;
  endfunction

endpackage

// File: rtl/sdam_clk_gen.sv
// Free-running SDAM serial clock generator.
// scl toggles every HALF_DIV clk cycles (50% duty, starts low after reset).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   scl_o        registered serial clock
//   fall_tick_c  combinational; high in the clk cycle whose rising edge
//                drives scl from 1 to 0
module sdam_clk_gen #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic scl_o,
  output logic fall_tick_c
);

  localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scl_q, scl_d;
  logic             wrap_c;

  // Half-period counter; scl flips on every wrap.
  always_comb begin
    wrap_c = (cnt_q == CNT_MAX);
    cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
    scl_d  = wrap_c ? ~scl_q : scl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      scl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      scl_q <= scl_d;
    end
  end

  assign scl_o       = scl_q;
  assign fall_tick_c = wrap_c & scl_q;

endmodule

// File: rtl/sdam_tx.sv
// SDAM serial write-frame transmitter.
// Accepts one address/data request via valid/ready and serialises
// start, mode, addr[0..7], data[0..15], (parity), stop on sda, changing
// sda only when scl falls so it is stable at every scl rising edge.
// Optional feature macro: SDAM_TX_PARITY_EN inserts an even-parity bit
// between the data and stop bits (28-bit frame instead of 27).
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_valid, in_ready  request handshake; ain/din sampled on acceptance
//   ain, din            address and data to send
//   scl, sda            serial link clock and data (sda idles high)
//   busy                a frame is pending or being transmitted
//   done                one-clk pulse when the stop bit completes
module sdam_tx
  import sdam_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SDAM_ADDR_W-1:0] ain,
  input  logic [SDAM_DATA_W-1:0] din,
  output logic                   scl,
  output logic                   sda,
  output logic                   busy,
  output logic                   done
);

  localparam logic [SDAM_BIT_CNT_W-1:0] ADDR_LAST = SDAM_BIT_CNT_W'(SDAM_ADDR_W - 1);
  localparam logic [SDAM_BIT_CNT_W-1:0] DATA_LAST = SDAM_BIT_CNT_W'(SDAM_DATA_W - 1);

  logic                      fall_tick_c;
  logic                      accept_c;
  sdam_state_e               state_q, state_d;
  sdam_req_t                 req_q, req_d;
  logic [SDAM_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                      pend_q, pend_d;
  logic                      sda_q, sda_d;
  logic                      rdy_q, rdy_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef SDAM_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  sdam_clk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .scl_o      (scl),
    .fall_tick_c(fall_tick_c)
  );

  // Frame sequencing on scl falling edges plus the request handshake.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    bit_cnt_d = bit_cnt_q;
    pend_d    = pend_q;
    sda_d     = sda_q;
    rdy_d     = rdy_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SDAM_TX_PARITY_EN
    par_d     = par_q;
`endif
    accept_c  = in_valid & rdy_q;

    if (fall_tick_c) begin
      case (state_q)
        ST_IDLE: begin
          sda_d = SDAM_IDLE_LVL;
          if (pend_q) begin
            state_d = ST_START;
            sda_d   = SDAM_START_BIT;
            pend_d  = 1'b0;
          end
        end
        ST_START: begin
          state_d = ST_MODE;
          sda_d   = SDAM_MODE_WR;
        end
        ST_MODE: begin
          state_d   = ST_ADDR;
          sda_d     = req_q.addr[0];
          bit_cnt_d = '0;
        end
        // Address and data are shifted right so bit 0 is always the next bit.
        ST_ADDR: begin
          if (bit_cnt_q == ADDR_LAST) begin
            state_d   = ST_DATA;
            sda_d     = req_q.data[0];
            bit_cnt_d = '0;
          end else begin
            req_d.addr = req_q.addr >> 1;
            sda_d      = req_q.addr[1];
            bit_cnt_d  = bit_cnt_q + SDAM_BIT_CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_cnt_q == DATA_LAST) begin
`ifdef SDAM_TX_PARITY_EN
            state_d = ST_PARITY;
            sda_d   = par_q;
`else
            state_d = ST_STOP;
            sda_d   = SDAM_IDLE_LVL;
`endif
            bit_cnt_d = '0;
          end else begin
            req_d.data = req_q.data >> 1;
            sda_d      = req_q.data[1];
            bit_cnt_d  = bit_cnt_q + SDAM_BIT_CNT_W'(1);
          end
        end
`ifdef SDAM_TX_PARITY_EN
        ST_PARITY: begin
          state_d = ST_STOP;
          sda_d   = SDAM_IDLE_LVL;
        end
`endif
        ST_STOP: begin
          state_d = ST_IDLE;
          sda_d   = SDAM_IDLE_LVL;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          sda_d   = SDAM_IDLE_LVL;
        end
      endcase
    end

    // Ready returns the cycle after the done pulse.
    if (done_q) begin
      rdy_d  = 1'b1;
      busy_d = 1'b0;
    end

    // Acceptance only happens while idle, so it never collides with shifting.
    if (accept_c) begin
      req_d.addr = ain;
      req_d.data = din;
      pend_d     = 1'b1;
      rdy_d      = 1'b0;
      busy_d     = 1'b1;
`ifdef SDAM_TX_PARITY_EN
      par_d      = sdam_parity(req_d);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      bit_cnt_q <= '0;
      pend_q    <= 1'b0;
      sda_q     <= SDAM_IDLE_LVL;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SDAM_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      bit_cnt_q <= bit_cnt_d;
      pend_q    <= pend_d;
      sda_q     <= sda_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SDAM_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign in_ready = rdy_q;
  assign sda      = sda_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
